seq_add_scheduler: RTL and testbench

SEQ_ADD_SCHEDULER -- requirements
Module: seq_add_scheduler

---
 rtl/seq_add_scheduler.sv | 147 ++++++++++++++
 tb/tb_seq_add_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_add_scheduler.sv
// Queues operand pairs and issues them one at a time to a serial adder (IDLE/ISSUE/WAIT).
// Push->issue latency 2 cycles; s_ready low when FIFO full; issue stalls while a result is unaccepted.
module seq_add_scheduler #(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2*DWIDTH+4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DWIDTH-1:0]          s_a,
  input  logic [DWIDTH-1:0]          s_b,
  output logic [DWIDTH-1:0]          add_in1,
  output logic [DWIDTH-1:0]          add_in2,
  output logic                       add_ivalid,
  input  logic [DWIDTH-1:0]          add_sum,
  input  logic                       add_carry,
  input  logic                       add_ovalid,
  input  logic                       add_busy,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DWIDTH:0]            m_sum,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_timeout,
  output logic                       err_spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;

  logic [2*DWIDTH-1:0] mem_q [DEPTH];
  logic [2*DWIDTH-1:0] head;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DWIDTH-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic                ivalid_q, ivalid_d;
  logic                m_valid_q, m_valid_d;
  logic [DWIDTH:0]     m_sum_q, m_sum_d;
  logic                err_to_q, err_to_d;
  logic                err_sp_q, err_sp_d;
  logic                do_push, do_pop;

  assign s_ready = (level_q != LW'(DEPTH));
  assign do_push = s_valid && s_ready;
  // The head was already copied into add_in1/add_in2 on entry to ISSUE, so pop there.
  assign do_pop  = (state_q == ISSUE);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {s_a, s_b};
  end

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    ivalid_d  = 1'b0;
    m_valid_d = m_valid_q;
    m_sum_d   = m_sum_q;
    err_to_d  = err_to_q;
    err_sp_d  = err_sp_q;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (add_ovalid && state_q != WAIT) err_sp_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (level_q != '0 && !m_valid_q && !add_busy) begin
          state_d        = ISSUE;
          ivalid_d       = 1'b1;
          {in1_d, in2_d} = head;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (add_ovalid) begin
          m_sum_d   = {add_carry, add_sum};
          m_valid_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Operation abandoned: no result is produced for it.
          err_to_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      ivalid_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_sum_q   <= '0;
      err_to_q  <= 1'b0;
      err_sp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      ivalid_q  <= ivalid_d;
      m_valid_q <= m_valid_d;
      m_sum_q   <= m_sum_d;
      err_to_q  <= err_to_d;
      err_sp_q  <= err_sp_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign add_in1      = in1_q;
  assign add_in2      = in2_q;
  assign add_ivalid   = ivalid_q;
  assign m_valid      = m_valid_q;
  assign m_sum        = m_sum_q;
  assign level        = level_q;
  assign err_timeout  = err_to_q;
  assign err_spurious = err_sp_q;

endmodule

// File: tb/tb_seq_add_scheduler.sv
// Directed bench for seq_add_scheduler with a behavioural serial adder model.
module tb_seq_add_scheduler;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 2*DW+4;

  logic          clk;
  logic          rstn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_a, s_b;
  logic [DW-1:0] add_in1, add_in2;
  logic          add_ivalid;
  logic [DW-1:0] add_sum;
  logic          add_carry;
  logic          add_ovalid;
  logic          add_busy;
  logic          m_valid;
  logic          m_ready;
  logic [DW:0]   m_sum;
  logic [2:0]    level;
  logic          err_timeout, err_spurious;

  seq_add_scheduler #(.DWIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .add_in1(add_in1), .add_in2(add_in2), .add_ivalid(add_ivalid),
    .add_sum(add_sum), .add_carry(add_carry), .add_ovalid(add_ovalid), .add_busy(add_busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .level(level),
    .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial adder model: busy for DW cycles after a load, then a one-cycle result pulse.
  logic          mdl_busy, mdl_ovalid, mdl_carry, mute, spur;
  logic [DW-1:0] mdl_sum, op_a, op_b;
  int            mdl_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdl_busy <= 1'b0; mdl_ovalid <= 1'b0; mdl_cnt <= 0;
      mdl_sum <= '0; mdl_carry <= 1'b0; op_a <= '0; op_b <= '0;
    end else begin
      mdl_ovalid <= 1'b0;
      if (add_ivalid) begin
        mdl_busy <= 1'b1; mdl_cnt <= DW; op_a <= add_in1; op_b <= add_in2;
      end else if (mdl_busy) begin
        if (mdl_cnt == 1) begin
          mdl_busy <= 1'b0;
          if (!mute) begin
            mdl_ovalid <= 1'b1;
            {mdl_carry, mdl_sum} <= {1'b0, op_a} + {1'b0, op_b};
          end
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
    end
  end

  assign add_busy   = mdl_busy;
  assign add_sum    = mdl_sum;
  assign add_carry  = mdl_carry;
  assign add_ovalid = mdl_ovalid | spur;

  int            cyc = 0;
  int            iv_total = 0;
  int            last_iv_cyc = 0;
  int            mv_total = 0;
  logic [DW-1:0] last_in1 = '0, last_in2 = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (add_ivalid) begin
      iv_total    <= iv_total + 1;
      last_iv_cyc <= cyc;
      last_in1    <= add_in1;
      last_in2    <= add_in2;
    end
    if (m_valid) mv_total <= mv_total + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, output int ref_cyc);
    int n;
    n = 0;
    s_a = a; s_b = b; s_valid = 1'b1;
    while (!s_ready && n < 200) begin step(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL push_wait: s_ready never rose for a=0x%0h b=0x%0h", a, b);
    end
    ref_cyc = cyc;
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input string name);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin step(); n++; end
    check(name, m_valid, 1);
  endtask

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   sum;
  } vec_t;

  vec_t       vecs[5];
  vec_t       bp[5];
  logic [DW:0] res[5];

  initial begin
    int r, base, n, got, c0, t_err, iv_snap, mv_snap;
    vecs[0] = '{8'h0F, 8'h01, 9'h010};
    vecs[1] = '{8'hFF, 8'h01, 9'h100};
    vecs[2] = '{8'hAA, 8'h55, 9'h0FF};
    vecs[3] = '{8'h00, 8'h00, 9'h000};
    vecs[4] = '{8'h80, 8'h80, 9'h100};
    bp[0] = '{8'h01, 8'h02, 9'h003};
    bp[1] = '{8'h03, 8'h04, 9'h007};
    bp[2] = '{8'h0A, 8'h14, 9'h01E};
    bp[3] = '{8'hF0, 8'h20, 9'h110};
    bp[4] = '{8'h7F, 8'h7F, 9'h0FE};

    rstn = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0; mute = 1'b0; spur = 1'b0;
    repeat (2) step();
    check("rst_level", level, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_ivalid", add_ivalid, 0);
    check("rst_in1", add_in1, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_sum", m_sum, 0);
    check("rst_errs", {err_timeout, err_spurious}, 0);
    rstn = 1'b1;
    step();

    foreach (vecs[i]) begin
      base = iv_total;
      push(vecs[i].a, vecs[i].b, r);
      wait_mvalid("vec_done");
      check("vec_sum", m_sum, vecs[i].sum);
      check("vec_pulses", iv_total - base, 1);
      check("vec_in1", last_in1, vecs[i].a);
      check("vec_in2", last_in2, vecs[i].b);
      check("vec_latency", last_iv_cyc - r, 2);
      repeat (3) step();
      check("vec_hold", m_valid, 1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("vec_clear", m_valid, 0);
      check("vec_sum_kept", m_sum, vecs[i].sum);
    end

    // Backpressure: downstream stalled, FIFO fills behind the held result.
    base = iv_total;
    foreach (bp[i]) push(bp[i].a, bp[i].b, r);
    wait_mvalid("bp_first");
    check("bp_level_full", level, 4);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_one_issue", iv_total - base, 1);
    s_a = 8'h55; s_b = 8'h66; s_valid = 1'b1;
    repeat (4) step();
    check("bp_sixth_stalled_level", level, 4);
    check("bp_sixth_stalled_rdy", s_ready, 0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    got = 0; n = 0;
    while (got < 5 && n < 400) begin
      if (m_valid) begin res[got] = m_sum; got++; end
      step(); n++;
    end
    m_ready = 1'b0;
    check("bp_count", got, 5);
    for (int i = 0; i < 5; i++) check("bp_order", res[i], bp[i].sum);
    repeat (3) step();
    check("bp_level_empty", level, 0);
    check("bp_issues", iv_total - base, 5);

    // Timeout: first operation never answers, queued one follows immediately.
    check("pre_timeout_flag", err_timeout, 0);
    mute = 1'b1;
    base = iv_total;
    push(8'h11, 8'h22, r);
    n = 0;
    while (iv_total - base < 1 && n < 50) begin step(); n++; end
    check("to_first_issue", iv_total - base, 1);
    c0 = last_iv_cyc;
    push(8'h33, 8'h44, r);
    n = 0;
    while (!err_timeout && n < 100) begin step(); n++; end
    t_err = cyc;
    check("to_flag", err_timeout, 1);
    check("to_exact", t_err - (c0 + 1), TIMEOUT);
    check("to_no_result", m_valid, 0);
    mute = 1'b0;
    n = 0;
    while (iv_total - base < 2 && n < 50) begin step(); n++; end
    check("to_next_issue", iv_total - base, 2);
    check("to_next_cyc", last_iv_cyc - c0, TIMEOUT + 2);
    check("to_next_in1", last_in1, 8'h33);
    check("to_next_in2", last_in2, 8'h44);
    wait_mvalid("to_next_done");
    check("to_next_sum", m_sum, 9'h077);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    repeat (2) step();

    // Spurious result pulse while idle.
    check("pre_spur_flag", err_spurious, 0);
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    check("spur_flag", err_spurious, 1);
    check("spur_m_valid", m_valid, 0);
    check("spur_level", level, 0);
    check("spur_timeout_sticky", err_timeout, 1);

    // Reset in the middle of WAIT with pairs queued.
    base = iv_total;
    push(8'h01, 8'h01, r);
    push(8'h02, 8'h02, r);
    push(8'h03, 8'h03, r);
    n = 0;
    while (iv_total - base < 1 && n < 50) begin step(); n++; end
    step();
    check("mid_level_nonzero", level != 0, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_s_ready", s_ready, 1);
    check("mid_rst_ivalid", add_ivalid, 0);
    check("mid_rst_in", {add_in1, add_in2}, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_sum", m_sum, 0);
    check("mid_rst_errs", {err_timeout, err_spurious}, 0);
    step();
    rstn = 1'b1;
    iv_snap = iv_total;
    mv_snap = mv_total;
    repeat (40) step();
    check("post_rst_no_issue", iv_total - iv_snap, 0);
    check("post_rst_no_result", mv_total - mv_snap, 0);
    check("post_rst_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
